// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, buffers a
// fetched word across downstream stalls, and drains stale requests after a redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Branch_taken,
  input  logic [31:0] BranchAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        IF_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] discard_addr_q, discard_addr_d;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = BranchAddr & 32'hFFFF_FFFC;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    hold_instr_d   = hold_instr_q;
    discard_addr_d = discard_addr_q;
    case (state_q)
      FETCH: begin
        if (Branch_taken) begin
          pc_d = branch_target;
          // An unanswered request cannot be withdrawn; remember it and drain it.
          if (!imem_ready) begin
            discard_addr_d = pc_q;
            state_d        = DISCARD;
          end
        end else if (imem_ready) begin
          if (freeze) begin
            hold_instr_d = imem_rdata;
            state_d      = HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (Branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end else if (!freeze) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        if (Branch_taken) begin
          pc_d = branch_target;
        end
        if (imem_ready) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    IF_valid    = 1'b0;
    Instruction = '0;
    PC          = pc_plus4;
    if (rst) begin
      PC = RESET_PC + 32'd4;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req    = 1'b1;
          IF_valid    = imem_ready && !Branch_taken;
          Instruction = (imem_ready && !Branch_taken) ? imem_rdata : '0;
        end
        HOLD: begin
          IF_valid    = !Branch_taken;
          Instruction = Branch_taken ? '0 : hold_instr_q;
        end
        DISCARD: begin
          imem_req  = 1'b1;
          imem_addr = discard_addr_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      hold_instr_q   <= '0;
      discard_addr_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      hold_instr_q   <= hold_instr_d;
      discard_addr_q <= discard_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        Branch_taken;
  logic [31:0] BranchAddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        IF_valid;

  int n_pass  = 0;
  int n_total = 0;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .Branch_taken(Branch_taken),
    .BranchAddr  (BranchAddr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .PC          (PC),
    .Instruction (Instruction),
    .IF_valid    (IF_valid)
  );

  always #5 clk = ~clk;

  // Model: next address to fetch, an optional buffered word waiting out a stall,
  // and an optional stale request that must be answered before fetching resumes.
  logic [31:0] m_next;
  logic        m_buf_full;
  logic [31:0] m_buf;
  logic        m_stale;
  logic [31:0] m_stale_addr;

  always @(posedge clk) begin
    if (rst) begin
      m_next     = 32'h0;
      m_buf_full = 1'b0;
      m_buf      = 32'h0;
      m_stale    = 1'b0;
    end else if (m_stale) begin
      if (Branch_taken) m_next = {BranchAddr[31:2], 2'b00};
      if (imem_ready) m_stale = 1'b0;
    end else if (m_buf_full) begin
      if (Branch_taken) begin
        m_next     = {BranchAddr[31:2], 2'b00};
        m_buf_full = 1'b0;
      end else if (!freeze) begin
        m_next     = m_next + 32'd4;
        m_buf_full = 1'b0;
      end
    end else begin
      if (Branch_taken) begin
        if (!imem_ready) begin
          m_stale      = 1'b1;
          m_stale_addr = m_next;
        end
        m_next = {BranchAddr[31:2], 2'b00};
      end else if (imem_ready) begin
        if (freeze) begin
          m_buf_full = 1'b1;
          m_buf      = imem_rdata;
        end else begin
          m_next = m_next + 32'd4;
        end
      end
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endfunction

  task automatic compare_model();
    logic        e_req, e_val;
    logic [31:0] e_addr, e_ins, e_pc;
    e_pc = m_next + 32'd4;
    e_addr = m_next;
    if (rst) begin
      e_req = 1'b0; e_val = 1'b0; e_ins = 32'h0; e_pc = 32'h4;
    end else if (m_stale) begin
      e_req = 1'b1; e_addr = m_stale_addr; e_val = 1'b0; e_ins = 32'h0;
    end else if (m_buf_full) begin
      e_req = 1'b0; e_val = !Branch_taken; e_ins = e_val ? m_buf : 32'h0;
    end else begin
      e_req = 1'b1; e_val = imem_ready && !Branch_taken; e_ins = e_val ? imem_rdata : 32'h0;
    end
    chk("model_req", {31'h0, imem_req}, {31'h0, e_req});
    if (e_req) chk("model_addr", imem_addr, e_addr);
    chk("model_valid", {31'h0, IF_valid}, {31'h0, e_val});
    chk("model_instr", Instruction, e_ins);
    if (e_val || rst) chk("model_pc", PC, e_pc);
  endtask

  task automatic cyc(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic rd, input logic [31:0] rdv);
    @(negedge clk);
    rst = r; freeze = f; Branch_taken = b; BranchAddr = ba; imem_ready = rd; imem_rdata = rdv;
    #1;
    compare_model();
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  initial begin
    rst = 1'b1; freeze = 1'b0; Branch_taken = 1'b0; BranchAddr = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;

    // Reset outputs
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 32'h1234);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, IF_valid}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_pc", PC, 32'h4);

    // Zero-wait streaming
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 32'h1000 + i);
      chk("zw_addr", imem_addr, 32'(i * 4));
      chk("zw_pc", PC, 32'(i * 4 + 4));
      chk("zw_valid", {31'h0, IF_valid}, 32'h1);
    end

    // Two wait states at address 0
    cyc(1, 0, 0, 0, 0, 0);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, (i == 2), (i == 2) ? 32'hE3A0_1005 : 32'h0);
      chk("ws_req", {31'h0, imem_req}, 32'h1);
      chk("ws_addr", imem_addr, 32'h0);
      chk("ws_valid", {31'h0, IF_valid}, (i == 2) ? 32'h1 : 32'h0);
    end
    chk("ws_instr", Instruction, 32'hE3A0_1005);
    cyc(0, 0, 0, 0, 0, 0);
    chk("ws_next_addr", imem_addr, 32'h4);

    // Freeze while ready: word held
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 32'hE081_2002);
    chk("frz_cap_valid", {31'h0, IF_valid}, 32'h1);
    for (int unsigned i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 32'hDEAD_BEEF);
      chk("hold_req", {31'h0, imem_req}, 32'h0);
      chk("hold_instr", Instruction, 32'hE081_2002);
      chk("hold_pc", PC, 32'h4);
      chk("hold_valid", {31'h0, IF_valid}, 32'h1);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h55);
    chk("hold_next_addr", imem_addr, 32'h4);

    // Redirect while address 8 outstanding
    cyc(0, 0, 1, 32'h100, 0, 0);
    chk("br_addr8", imem_addr, 32'h8);
    chk("br_valid", {31'h0, IF_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("disc_addr", imem_addr, 32'h8);
    chk("disc_valid", {31'h0, IF_valid}, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h77);
    chk("disc_addr2", imem_addr, 32'h8);
    chk("disc_valid2", {31'h0, IF_valid}, 32'h0);
    cyc(0, 1, 0, 0, 1, 32'h88);
    chk("br_target_addr", imem_addr, 32'h100);

    // Branch and freeze together in HOLD
    cyc(0, 1, 1, 32'h200, 0, 0);
    chk("hold_br_valid", {31'h0, IF_valid}, 32'h0);
    chk("hold_br_instr", Instruction, 32'h0);
    cyc(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h99);
    chk("hold_br_addr", imem_addr, 32'h200);
    chk("fetch_br_ready_valid", {31'h0, IF_valid}, 32'h0);

    // Wrap at the top of the address space, then reset out of DISCARD
    cyc(0, 0, 0, 0, 1, 32'hAA);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc", PC, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'hBB);
    chk("wrap_next_addr", imem_addr, 32'h0);
    cyc(0, 0, 1, 32'h40, 0, 0);
    chk("pre_disc_addr", imem_addr, 32'h4);
    cyc(1, 0, 0, 0, 0, 0);
    chk("disc_rst_req", {31'h0, imem_req}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);

    // Randomized traffic against the model
    for (int unsigned n = 0; n < 3000; n++) begin
      logic        r, f, b, rd;
      logic [31:0] ba, a;
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 9) < 3);
      b  = ($urandom_range(0, 9) == 0);
      rd = ($urandom_range(0, 9) < 6);
      ba = $urandom;
      a  = m_stale ? m_stale_addr : m_next;
      cyc(r, f, b, ba, rd, mem_word(a));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
